// File: rtl/sweep_ctrl.sv
// sweep_ctrl: drives an external up/down counter back and forth between a
// lower and an upper bound, with an optional hold at each endpoint and an
// optional fixed number of sweeps.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_valid / cfg_ready     configuration handshake (ready only in IDLE)
//   cfg_lo, cfg_hi            sweep bounds (lo must be below hi)
//   cfg_cycles                number of full sweeps, 0 = run until stopped
//   cfg_dwell                 extra hold cycles at each endpoint
//   stop                      abort the running sweep
//   ctr_count                 current value of the controlled counter
//   ctr_rst/enable/up_down    counter controls (up_down: 1 = up)
//   busy                      high outside IDLE
//   done, aborted, err        single-cycle status pulses
//   sweep_cnt                 sweeps completed since the last accept
module sweep_ctrl #(
  parameter int CNT_W   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_lo,
  input  logic [CNT_W-1:0]   cfg_hi,
  input  logic [CNT_W-1:0]   cfg_cycles,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               stop,
  input  logic [CNT_W-1:0]   ctr_count,
  output logic               ctr_rst,
  output logic               ctr_enable,
  output logic               ctr_up_down,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               err,
  output logic [CNT_W-1:0]   sweep_cnt
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, SEEK, UP, DWELL_HI, DOWN, DWELL_LO, DONE
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]   CNT_ZERO  = '0;
  localparam logic [DWELL_W-1:0] DWELL_ONE = 1;
  localparam logic [DWELL_W-1:0] DWELL_ZERO = '0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   hi_q, hi_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0]   sweep_cnt_q, sweep_cnt_d;
  logic               aborted_q, aborted_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   sweep_inc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      cycles_q    <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      sweep_cnt_q <= '0;
      aborted_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cycles_q    <= cycles_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      sweep_cnt_q <= sweep_cnt_d;
      aborted_q   <= aborted_d;
      err_q       <= err_d;
    end
  end

  assign sweep_inc = sweep_cnt_q + CNT_ONE;

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cycles_d    = cycles_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    sweep_cnt_d = sweep_cnt_q;
    aborted_d   = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_lo < cfg_hi) begin
            lo_d        = cfg_lo;
            hi_d        = cfg_hi;
            cycles_d    = cfg_cycles;
            dwell_d     = cfg_dwell;
            sweep_cnt_d = '0;
            state_d     = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = SEEK;
      SEEK: if (ctr_count == lo_q) state_d = UP;
      UP: begin
        if (ctr_count >= hi_q) begin
          dwell_cnt_d = dwell_q;
          state_d     = DWELL_HI;
        end
      end
      DWELL_HI: begin
        if (dwell_cnt_q == DWELL_ZERO) state_d = DOWN;
        else dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
      end
      DOWN: begin
        if (ctr_count <= lo_q) begin
          // sweep_cnt wraps naturally in continuous mode
          sweep_cnt_d = sweep_inc;
          if (cycles_q != CNT_ZERO && sweep_inc == cycles_q) begin
            state_d = DONE;
          end else begin
            dwell_cnt_d = dwell_q;
            state_d     = DWELL_LO;
          end
        end
      end
      DWELL_LO: begin
        if (dwell_cnt_q == DWELL_ZERO) state_d = UP;
        else dwell_cnt_d = dwell_cnt_q - DWELL_ONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort beats every other transition; the sweep count is frozen.
    if (stop && state_q != IDLE) begin
      state_d     = IDLE;
      aborted_d   = 1'b1;
      sweep_cnt_d = sweep_cnt_q;
      dwell_cnt_d = dwell_cnt_q;
    end
  end

  // Output decode: counter controls follow the registered state and the
  // live counter value so the counter moves in the same cycle.
  always_comb begin
    ctr_rst     = 1'b0;
    ctr_enable  = 1'b0;
    ctr_up_down = 1'b1;
    busy        = (state_q != IDLE);
    cfg_ready   = (state_q == IDLE);
    done        = (state_q == DONE) && !stop;

    case (state_q)
      CLEAR: ctr_rst = 1'b1;
      SEEK: begin
        if (ctr_count < lo_q) begin
          ctr_enable = 1'b1;
        end else if (ctr_count > lo_q) begin
          ctr_enable  = 1'b1;
          ctr_up_down = 1'b0;
        end
      end
      UP: if (ctr_count < hi_q) ctr_enable = 1'b1;
      DOWN: begin
        if (ctr_count > lo_q) begin
          ctr_enable  = 1'b1;
          ctr_up_down = 1'b0;
        end
      end
      default: ;
    endcase

    if (stop && state_q != IDLE) begin
      ctr_rst     = 1'b0;
      ctr_enable  = 1'b0;
      ctr_up_down = 1'b1;
    end
  end

  assign aborted   = aborted_q;
  assign err       = err_q;
  assign sweep_cnt = sweep_cnt_q;

endmodule
